mp_subtractor_seq: RTL and testbench
====================================

// Module: mp_subtractor_seq
// PURPOSE
// - Sequential multi-precision subtractor: computes oDiff = iA - iB - iBorrow on WIDTH-bit operands.
// - Reuses one CHUNK-bit borrow-select subtractor slice over WIDTH/CHUNK cycles, LSB chunk first.
// - Inverse-direction companion to the carry-select adders. Serves wide modular/bignum datapaths
//   where a full-width combinational subtractor does not meet timing or area.
// PARAMETERS
// - WIDTH  256  operand/result width in bits; WIDTH % CHUNK == 0; WIDTH/CHUNK >= 2
// - CHUNK  32   slice width processed per cycle; multiple of 8
// PORTS
// - iClk     in   1      clock; all state updates on rising edge
// - iRst     in   1      reset, asynchronous, active-high
// - iStart   in   1      request; sampled only in IDLE or DONE
// - iA       in   WIDTH  minuend; sampled with accepted iStart
// - iB       in   WIDTH  subtrahend; sampled with accepted iStart
// - iBorrow  in   1      borrow-in; sampled with accepted iStart
// - oBusy    out  1      high in BUSY
// - oDone    out  1      one-cycle pulse; oDiff/oBorrow valid
// - oDiff    out  WIDTH  result; held until the next oDone
// - oBorrow  out  1      borrow-out (1 = iA < iB + iBorrow, unsigned)
// BEHAVIOUR
// - Reset: state IDLE, chunk counter 0, oBusy=0, oDone=0, oDiff=0, oBorrow=0; operand/work regs cleared.
// - Let N = WIDTH/CHUNK. Counter is $clog2(N) bits.
// - FSM:
//   - IDLE -> BUSY on iStart. Latch iA, iB, iBorrow; counter=0.
//   - BUSY: each cycle computes chunk[cnt] = A[cnt] - B[cnt] - brw into the work register,
//     updates brw and increments cnt. After chunk N-1 -> DONE.
//   - DONE (1 cycle): oDone=1; oDiff <= work register; oBorrow <= final brw.
//     If iStart is high this cycle -> BUSY with new operands (back-to-back); else -> IDLE.
// - Latency: oDone is high in the cycle following the (N+1)th rising edge after the edge that sampled iStart.
// - Throughput: one result per N+1 cycles with back-to-back starts.
// - Outputs while computing:
//   - oDiff/oBorrow are not disturbed during BUSY; they update only on entry to DONE.
//   - oDone is registered and never high for more than one cycle per operation.
// - iStart high in BUSY is ignored; no queueing, no error flag.
// - iA/iB/iBorrow may change freely after the accepting edge.
// - Arithmetic: unsigned two's-complement, modulo 2^WIDTH. Borrow chains across chunks with no loss.
//   The slice computes both borrow-in cases and selects with the registered borrow.
// - Reset asserted mid-operation: immediate return to reset values; the partial result is discarded and
//   oDone is not pulsed. The first iStart after deassertion behaves normally.
// STRUCTURE
// - Shared package mp_arith_pkg:
//   - default CHUNK;
//   - FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
//   - N/counter-width helper constants.
// - One sub-module: subtractor_chunk (combinational CHUNK-bit borrow-select subtractor built from 8-bit
//   subtract blocks). Ports: iA, iB, iC (borrow-in), oDiff, oC (borrow-out).
// - Top level holds the FSM, counter, operand registers (or shift registers), work register and output registers.
// TESTING
// - Basic wrap (WIDTH=256): A=1, B=2, iBorrow=0 -> oDiff=2^256-1 (all F), oBorrow=1;
//   oDone exactly N+1=9 edges after start.
// - Cross-chunk borrow: A=2^32, B=1 -> oDiff=32'hFFFFFFFF in chunk 0, zero elsewhere, oBorrow=0.
// - Borrow-in: A=B=0x5A..5A with iBorrow=1 -> all F, oBorrow=1; same with iBorrow=0 -> 0, oBorrow=0.
// - Handshake:
//   - iStart held high through BUSY -> exactly one oDone; new operands applied in the DONE cycle are
//     accepted, and the second oDone follows N+1 edges later.
//   - oDiff is stable between pulses.
// - Reset mid-op: assert iRst at BUSY cycle 3 -> all outputs 0 asynchronously, no oDone;
//   the next op A=10, B=3 -> oDiff=7, oBorrow=0.
// - Random: 1000 ops vs a WIDTH-bit golden model, incl. A=0, B=2^256-1 and A=B; also run WIDTH=64, CHUNK=32.

Source files
------------

// File: rtl/mp_arith_pkg.sv
// Shared arithmetic package for the multi-precision datapath blocks:
// default sizes, FSM state encoding and chunk-count helpers.
package mp_arith_pkg;

    localparam int DEFAULT_WIDTH = 256;
    localparam int DEFAULT_CHUNK = 32;
    localparam int BLOCK         = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int numChunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk design would still need a one-bit counter.
    function automatic int cntWidth(input int width, input int chunk);
        return ((width / chunk) > 1) ? $clog2(width / chunk) : 1;
    endfunction

endpackage

// File: rtl/subtractor_chunk.sv
// Combinational CHUNK-bit borrow-select subtractor built from 8-bit blocks;
// each block precomputes both borrow-in cases and the incoming borrow picks one.
module subtractor_chunk
    import mp_arith_pkg::*;
#(
    parameter int CHUNK = DEFAULT_CHUNK
)
(
    input  logic [CHUNK-1:0] iA,
    input  logic [CHUNK-1:0] iB,
    input  logic             iC,
    output logic [CHUNK-1:0] oDiff,
    output logic             oC
);

    localparam int NB = CHUNK / BLOCK;

    logic [NB:0] borrow;

    assign borrow[0] = iC;

    for (genvar k = 0; k < NB; k++) begin : g_blk
        logic [BLOCK:0] diffNoBorrow;
        logic [BLOCK:0] diffBorrow;

        // Bit BLOCK of each 9-bit result is that block's borrow-out.
        assign diffNoBorrow = {1'b0, iA[k*BLOCK +: BLOCK]} - {1'b0, iB[k*BLOCK +: BLOCK]};
        assign diffBorrow   = {1'b0, iA[k*BLOCK +: BLOCK]} - {1'b0, iB[k*BLOCK +: BLOCK]}
                              - (BLOCK+1)'(1);

        assign oDiff[k*BLOCK +: BLOCK] = borrow[k] ? diffBorrow[BLOCK-1:0] : diffNoBorrow[BLOCK-1:0];
        assign borrow[k+1]             = borrow[k] ? diffBorrow[BLOCK]     : diffNoBorrow[BLOCK];
    end

    assign oC = borrow[NB];

endmodule

// File: rtl/mp_subtractor_seq.sv
// Sequential multi-precision subtractor: oDiff = iA - iB - iBorrow, one CHUNK-bit
// slice per cycle, LSB chunk first, result published one cycle after the last chunk.
module mp_subtractor_seq
    import mp_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
)
(
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iBorrow,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oDiff,
    output logic             oBorrow
);

    localparam int               N     = numChunks(WIDTH, CHUNK);
    localparam int               CNT_W = cntWidth(WIDTH, CHUNK);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

    state_t           stateQ, stateD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic [WIDTH-1:0] aQ, aD;
    logic [WIDTH-1:0] bQ, bD;
    logic [WIDTH-1:0] workQ, workD;
    logic [WIDTH-1:0] diffQ, diffD;
    logic             brwQ, brwD;
    logic             doneQ, doneD;
    logic             borrowQ, borrowD;

    logic [CHUNK-1:0] sliceDiff;
    logic             sliceBorrow;

    subtractor_chunk #(
        .CHUNK (CHUNK)
    ) uSlice (
        .iA    (aQ[CHUNK-1:0]),
        .iB    (bQ[CHUNK-1:0]),
        .iC    (brwQ),
        .oDiff (sliceDiff),
        .oC    (sliceBorrow)
    );

    // Operands shift right so the active chunk is always at the bottom; results
    // enter the work register from the top and land in place after N shifts.
    always_comb begin
        stateD  = stateQ;
        cntD    = cntQ;
        aD      = aQ;
        bD      = bQ;
        workD   = workQ;
        brwD    = brwQ;
        doneD   = 1'b0;
        diffD   = diffQ;
        borrowD = borrowQ;

        case (stateQ)
            IDLE: begin
                if (iStart) begin
                    aD     = iA;
                    bD     = iB;
                    brwD   = iBorrow;
                    cntD   = '0;
                    stateD = BUSY;
                end
            end
            BUSY: begin
                aD    = {{CHUNK{1'b0}}, aQ[WIDTH-1:CHUNK]};
                bD    = {{CHUNK{1'b0}}, bQ[WIDTH-1:CHUNK]};
                workD = {sliceDiff, workQ[WIDTH-1:CHUNK]};
                brwD  = sliceBorrow;
                cntD  = cntQ + CNT_W'(1);
                if (cntQ == LAST) begin
                    cntD   = '0;
                    stateD = DONE;
                end
            end
            DONE: begin
                doneD   = 1'b1;
                diffD   = workQ;
                borrowD = brwQ;
                stateD  = IDLE;
                if (iStart) begin
                    aD     = iA;
                    bD     = iB;
                    brwD   = iBorrow;
                    cntD   = '0;
                    stateD = BUSY;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            stateQ  <= IDLE;
            cntQ    <= '0;
            aQ      <= '0;
            bQ      <= '0;
            workQ   <= '0;
            brwQ    <= 1'b0;
            doneQ   <= 1'b0;
            diffQ   <= '0;
            borrowQ <= 1'b0;
        end else begin
            stateQ  <= stateD;
            cntQ    <= cntD;
            aQ      <= aD;
            bQ      <= bD;
            workQ   <= workD;
            brwQ    <= brwD;
            doneQ   <= doneD;
            diffQ   <= diffD;
            borrowQ <= borrowD;
        end
    end

    assign oBusy   = (stateQ == BUSY);
    assign oDone   = doneQ;
    assign oDiff   = diffQ;
    assign oBorrow = borrowQ;

endmodule

// File: tb/tb_mp_subtractor_seq.sv
// Scoreboard bench for mp_subtractor_seq: a 256/32 instance with directed and random
// operations plus a 64/32 instance with random operations, both against plain arithmetic.
module tb_mp_subtractor_seq;

    localparam int W  = 256;
    localparam int C  = 32;
    localparam int N  = W / C;
    localparam int WS = 64;
    localparam int NS = WS / C;

    logic         iClk = 1'b0;
    logic         iRst, iStart, iBorrow;
    logic [W-1:0] iA, iB;
    logic         oBusy, oDone, oBorrow;
    logic [W-1:0] oDiff;

    logic          sRst, sStart, sBorrowIn;
    logic [WS-1:0] sA, sB;
    logic          sBusy, sDone, sBorrowOut;
    logic [WS-1:0] sDiff;

    int compared   = 0;
    int mismatched = 0;
    int edgeCount  = 0;
    bit smallDone  = 1'b0;

    logic [W-1:0]  expDiffQ[$];
    logic          expBrwQ[$];
    int            expEdgeQ[$];
    logic [WS-1:0] sExpDiffQ[$];
    logic          sExpBrwQ[$];
    logic [W-1:0]  lastDiff = '0;

    mp_subtractor_seq #(.WIDTH(W), .CHUNK(C)) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iStart  (iStart),
        .iA      (iA),
        .iB      (iB),
        .iBorrow (iBorrow),
        .oBusy   (oBusy),
        .oDone   (oDone),
        .oDiff   (oDiff),
        .oBorrow (oBorrow)
    );

    mp_subtractor_seq #(.WIDTH(WS), .CHUNK(C)) dutSmall (
        .iClk    (iClk),
        .iRst    (sRst),
        .iStart  (sStart),
        .iA      (sA),
        .iB      (sB),
        .iBorrow (sBorrowIn),
        .oBusy   (sBusy),
        .oDone   (sDone),
        .oDiff   (sDiff),
        .oBorrow (sBorrowOut)
    );

    always #5 iClk = ~iClk;

    initial forever begin
        @(posedge iClk);
        edgeCount++;
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W:0] refSub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        return {1'b0, a} - {1'b0, b} - (W+1)'(bin);
    endfunction

    function automatic logic [WS:0] refSubSmall(input logic [WS-1:0] a, input logic [WS-1:0] b, input logic bin);
        return {1'b0, a} - {1'b0, b} - (WS+1)'(bin);
    endfunction

    function automatic logic [W-1:0] rndW();
        logic [W-1:0] r;
        for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Raises iStart at the first negedge where the DUT can accept, leaving it high.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        logic [W:0] full;
        int waited = 0;
        @(negedge iClk);
        while (oBusy && waited < 4 * N) begin
            @(negedge iClk);
            waited++;
        end
        if (oBusy) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL start_wait: oBusy got 1 expected 0 after %0d cycles", waited);
        end else begin
            iA      = a;
            iB      = b;
            iBorrow = bin;
            iStart  = 1'b1;
            full    = refSub(a, b, bin);
            expDiffQ.push_back(full[W-1:0]);
            expBrwQ.push_back(full[W]);
            expEdgeQ.push_back(edgeCount + 1);
            @(posedge iClk);
        end
    endtask

    task automatic releaseStart();
        @(negedge iClk);
        iStart = 1'b0;
        iA     = rndW();
        iB     = rndW();
    endtask

    task automatic drain();
        int waited = 0;
        while (expDiffQ.size() != 0 && waited < 4 * N + 4) begin
            @(negedge iClk);
            waited++;
        end
        if (expDiffQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: pending got %0d expected 0", expDiffQ.size());
            expDiffQ.delete();
            expBrwQ.delete();
            expEdgeQ.delete();
        end
    endtask

    task automatic applySmall(input logic [WS-1:0] a, input logic [WS-1:0] b, input logic bin);
        logic [WS:0] full;
        int waited = 0;
        @(negedge iClk);
        while (sBusy && waited < 4 * NS) begin
            @(negedge iClk);
            waited++;
        end
        if (sBusy) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL small_start_wait: sBusy got 1 expected 0");
        end else begin
            sA        = a;
            sB        = b;
            sBorrowIn = bin;
            sStart    = 1'b1;
            full      = refSubSmall(a, b, bin);
            sExpDiffQ.push_back(full[WS-1:0]);
            sExpBrwQ.push_back(full[WS]);
            @(posedge iClk);
        end
    endtask

    // Monitor for the wide instance: result, borrow, latency, and hold between pulses.
    initial forever begin
        logic [W-1:0] expD;
        logic         expB;
        int           expE;
        @(negedge iClk);
        if (iRst) begin
            lastDiff = '0;
        end else if (oDone) begin
            if (expDiffQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_done: oDone got 1 expected 0");
            end else begin
                expD = expDiffQ.pop_front();
                expB = expBrwQ.pop_front();
                expE = expEdgeQ.pop_front();
                checkOutput("diff", oDiff, expD);
                checkOutput("borrow", W'(oBorrow), W'(expB));
                checkOutput("latency", W'(edgeCount - expE), W'(N + 1));
            end
            lastDiff = oDiff;
        end else begin
            checkOutput("hold", oDiff, lastDiff);
        end
    end

    initial forever begin
        @(negedge iClk);
        if (!sRst && sDone) begin
            if (sExpDiffQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL small_unexpected_done: sDone got 1 expected 0");
            end else begin
                checkOutput("small_diff", W'(sDiff), W'(sExpDiffQ.pop_front()));
                checkOutput("small_borrow", W'(sBorrowOut), W'(sExpBrwQ.pop_front()));
            end
        end
    end

    initial begin
        sRst = 1'b1; sStart = 1'b0; sA = '0; sB = '0; sBorrowIn = 1'b0;
        repeat (3) @(negedge iClk);
        sRst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            logic [WS-1:0] a, b;
            a = {$urandom, $urandom};
            b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
            applySmall(a, b, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0) begin
                @(negedge iClk);
                sStart = 1'b0;
            end
        end
        @(negedge iClk);
        sStart = 1'b0;
        repeat (4 * NS) @(negedge iClk);
        if (sExpDiffQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL small_drain: pending got %0d expected 0", sExpDiffQ.size());
        end
        smallDone = 1'b1;
    end

    initial begin
        iRst = 1'b1; iStart = 1'b0; iA = '0; iB = '0; iBorrow = 1'b0;
        repeat (2) @(negedge iClk);
        checkOutput("reset_busy", W'(oBusy), '0);
        checkOutput("reset_done", W'(oDone), '0);
        checkOutput("reset_diff", oDiff, '0);
        checkOutput("reset_borrow", W'(oBorrow), '0);
        iRst = 1'b0;

        applyStimulus(W'(1), W'(2), 1'b0);
        releaseStart();
        applyStimulus(W'(1) << 32, W'(1), 1'b0);
        releaseStart();
        applyStimulus({32{8'h5A}}, {32{8'h5A}}, 1'b1);
        releaseStart();
        applyStimulus({32{8'h5A}}, {32{8'h5A}}, 1'b0);
        releaseStart();
        drain();

        // iStart stays high through the first operation; second operands land in DONE.
        applyStimulus(rndW(), rndW(), 1'b0);
        applyStimulus(W'(7), rndW() | (W'(1) << (W - 1)), 1'b1);
        releaseStart();
        drain();

        // Abort in the third BUSY cycle; outputs must clear without waiting for a clock.
        @(negedge iClk);
        iA = rndW(); iB = rndW(); iBorrow = 1'b1; iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        repeat (2) @(negedge iClk);
        #2 iRst = 1'b1;
        #1;
        checkOutput("abort_busy", W'(oBusy), '0);
        checkOutput("abort_done", W'(oDone), '0);
        checkOutput("abort_diff", oDiff, '0);
        checkOutput("abort_borrow", W'(oBorrow), '0);
        @(negedge iClk);
        #2 iRst = 1'b0;
        repeat (N + 3) @(negedge iClk);
        applyStimulus(W'(10), W'(3), 1'b0);
        releaseStart();
        drain();

        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] a, b;
            case ($urandom_range(0, 7))
                0:       begin a = '0;     b = '1;     end
                1:       begin a = rndW(); b = a;      end
                default: begin a = rndW(); b = rndW(); end
            endcase
            applyStimulus(a, b, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                releaseStart();
                repeat ($urandom_range(0, 2)) @(negedge iClk);
            end
        end
        releaseStart();
        drain();

        for (int k = 0; k < 100 && !smallDone; k++) @(negedge iClk);
        if (!smallDone) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL small_finish: done flag got 0 expected 1");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
